memory_access_sequencer: RTL and testbench

- Sequences every control-unit memory operation onto the byte-wide RAM port.
- Serialises byte, halfword and word transfers into byte beats, inserting programmable wait states, and assembles or splits data big-endian.
- Produces the MFC (memory function complete) handshake that the microsequencer tests. It sits between the control-signal field and datapath MDR/MAR on one side and the RAM on the other.

---
 rtl/memory_access_sequencer.sv | 178 +++++++++++++++++
 tb/tb_memory_access_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_sequencer.sv
// Memory access sequencer: turns byte/halfword/word control-unit memory
// operations into byte beats on a byte-wide RAM port. Beats are big-endian,
// each beat lasts WAIT_STATES+1 cycles, and MFC/MemErr form a four-phase
// handshake with the microsequencer.
module memory_access_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              MemErr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              ram_en,
    output logic              ram_we
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned IDX_W  = 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base, base_n;
    logic              rw_q, rw_n;
    logic [31:0]       data_q, data_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [IDX_W-1:0]  last, last_n;
    logic [WAIT_W-1:0] wcnt, wcnt_n;
    logic [23:0]       asm_q, asm_n;
    logic [31:0]       dout_n;

    logic              beat_n;
    logic              misalign;
    logic [IDX_W-1:0]  sel;
    logic [7:0]        wbyte;
    logic              ram_en_n;
    logic              ram_we_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [7:0]        ram_wdata_n;
    logic              mfc_n;
    logic              err_n;

    // Next-state, datapath and next-output decode; outputs are registered
    // from the next state so they line up with the state they describe.
    always_comb begin
        state_n  = state;
        base_n   = base;
        rw_n     = rw_q;
        data_n   = data_q;
        idx_n    = idx;
        last_n   = last;
        wcnt_n   = wcnt;
        asm_n    = asm_q;
        dout_n   = DataOut;
        misalign = 1'b0;

        case (state)
            IDLE: begin
                if (MOV) begin
                    base_n = Addr;
                    rw_n   = RW;
                    data_n = DataIn;
                    idx_n  = '0;
                    wcnt_n = WAIT_INIT;
                    asm_n  = '0;
                    case (Size)
                        2'b00:   last_n = 2'd0;
                        2'b01:   last_n = 2'd1;
                        default: last_n = 2'd3;
                    endcase
                    misalign = (Size == 2'b11)
                             || ((Size == 2'b01) && Addr[0])
                             || ((Size == 2'b10) && (Addr[1:0] != 2'b00));
                    state_n = misalign ? ERR : BEAT;
                end
            end
            BEAT: begin
                if (wcnt == '0) begin
                    if (rw_q) begin
                        asm_n = {asm_q[15:0], ram_rdata};
                    end
                    if (idx == last) begin
                        state_n = DONE;
                        if (rw_q) begin
                            dout_n = {asm_q, ram_rdata};
                        end
                    end else begin
                        idx_n  = idx + 2'd1;
                        wcnt_n = WAIT_INIT;
                    end
                end else begin
                    wcnt_n = wcnt - 4'd1;
                end
            end
            DONE: begin
                if (!MOV) begin
                    state_n = IDLE;
                end
            end
            ERR: begin
                if (!MOV) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Byte (N-1-index) of the latched value: index 0 carries the MSB.
        sel = last_n - idx_n;
        case (sel)
            2'd0:    wbyte = data_n[7:0];
            2'd1:    wbyte = data_n[15:8];
            2'd2:    wbyte = data_n[23:16];
            default: wbyte = data_n[31:24];
        endcase

        beat_n      = (state_n == BEAT);
        ram_en_n    = beat_n;
        ram_we_n    = beat_n && !rw_n;
        ram_addr_n  = beat_n ? (base_n + ADDR_W'(idx_n)) : '0;
        ram_wdata_n = (beat_n && !rw_n) ? wbyte : 8'h00;
        mfc_n       = (state_n == DONE) || (state_n == ERR);
        err_n       = (state_n == ERR);
    end

    // State, latched request and registered outputs; async reset clears all.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            base      <= '0;
            rw_q      <= 1'b0;
            data_q    <= '0;
            idx       <= '0;
            last      <= '0;
            wcnt      <= '0;
            asm_q     <= '0;
            DataOut   <= '0;
            MFC       <= 1'b0;
            MemErr    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            state     <= state_n;
            base      <= base_n;
            rw_q      <= rw_n;
            data_q    <= data_n;
            idx       <= idx_n;
            last      <= last_n;
            wcnt      <= wcnt_n;
            asm_q     <= asm_n;
            DataOut   <= dout_n;
            MFC       <= mfc_n;
            MemErr    <= err_n;
            ram_addr  <= ram_addr_n;
            ram_wdata <= ram_wdata_n;
            ram_en    <= ram_en_n;
            ram_we    <= ram_we_n;
        end
    end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench for memory_access_sequencer: one instance with one wait
// state, one with zero wait states, each backed by a small RAM model.
module tb_memory_access_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MOV, MOV0;
    logic        RW;
    logic [1:0]  Size;
    logic [7:0]  Addr;
    logic [31:0] DataIn;

    logic [31:0] DataOut, DataOut0;
    logic        MFC, MFC0, MemErr, MemErr0;
    logic [7:0]  ram_addr, ram_addr0, ram_wdata, ram_wdata0;
    logic [7:0]  ram_rdata, ram_rdata0;
    logic        ram_en, ram_en0, ram_we, ram_we0;

    logic [7:0]  mem1 [256];
    logic [7:0]  mem0 [256];
    int          wr_count1 = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    memory_access_sequencer #(.ADDR_W(8), .WAIT_STATES(1)) u_dut (
        .CLK(CLK), .Reset(Reset), .MOV(MOV), .RW(RW), .Size(Size),
        .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC),
        .MemErr(MemErr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_en(ram_en), .ram_we(ram_we)
    );

    memory_access_sequencer #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .CLK(CLK), .Reset(Reset), .MOV(MOV0), .RW(RW), .Size(Size),
        .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut0), .MFC(MFC0),
        .MemErr(MemErr0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_rdata(ram_rdata0), .ram_en(ram_en0), .ram_we(ram_we0)
    );

    assign ram_rdata  = mem1[ram_addr];
    assign ram_rdata0 = mem0[ram_addr0];

    // RAM models: write whenever a write strobe is seen at an edge.
    always @(posedge CLK) begin
        if (ram_en && ram_we) begin
            mem1[ram_addr] <= ram_wdata;
            wr_count1      <= wr_count1 + 1;
        end
        if (ram_en0 && ram_we0) begin
            mem0[ram_addr0] <= ram_wdata0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int wr_snap;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem0[i] = 8'h00;
        end
        mem1[8'h10] = 8'hDE; mem1[8'h11] = 8'hAD;
        mem1[8'h12] = 8'hBE; mem1[8'h13] = 8'hEF;
        mem1[8'h30] = 8'h12; mem1[8'h31] = 8'h34;
        mem1[8'h32] = 8'h56; mem1[8'h33] = 8'h78;
        mem0[8'hFF] = 8'h80;

        Reset = 1'b1; MOV = 1'b0; MOV0 = 1'b0; RW = 1'b0;
        Size = 2'b00; Addr = 8'h00; DataIn = 32'h0;
        tick(); tick();
        check("rst_mfc",     32'(MFC),      32'd0);
        check("rst_memerr",  32'(MemErr),   32'd0);
        check("rst_ram_en",  32'(ram_en),   32'd0);
        check("rst_dataout", DataOut,       32'd0);
        Reset = 1'b0;
        tick();

        // Word read, one wait state.
        MOV = 1'b1; RW = 1'b1; Size = 2'b10; Addr = 8'h10;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("wr_rd_en",   32'(ram_en),   32'd1);
            check("wr_rd_we",   32'(ram_we),   32'd0);
            check("wr_rd_addr", 32'(ram_addr), 32'(8'h10 + 8'(i / 2)));
            check("wr_rd_mfc",  32'(MFC),      32'd0);
            tick();
        end
        check("wr_rd_mfc_up", 32'(MFC),    32'd1);
        check("wr_rd_err",    32'(MemErr), 32'd0);
        check("wr_rd_data",   DataOut,     32'hDEADBEEF);
        check("wr_rd_en_off", 32'(ram_en), 32'd0);
        tick();
        check("wr_rd_mfc_hold", 32'(MFC), 32'd1);
        MOV = 1'b0;
        tick();
        check("wr_rd_mfc_down", 32'(MFC), 32'd0);
        tick();

        // Halfword write at 0x22.
        MOV = 1'b1; RW = 1'b0; Size = 2'b01; Addr = 8'h22; DataIn = 32'h0000A5C3;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("hw_wr_we",    32'(ram_we),    32'd1);
            check("hw_wr_addr",  32'(ram_addr),  (i < 2) ? 32'h22 : 32'h23);
            check("hw_wr_wdata", 32'(ram_wdata), (i < 2) ? 32'hA5 : 32'hC3);
            check("hw_wr_mfc",   32'(MFC),       32'd0);
            tick();
        end
        check("hw_wr_mfc_up", 32'(MFC),      32'd1);
        check("hw_wr_err",    32'(MemErr),   32'd0);
        check("hw_wr_we_off", 32'(ram_we),   32'd0);
        check("hw_wr_mem22",  32'(mem1[8'h22]), 32'hA5);
        check("hw_wr_mem23",  32'(mem1[8'h23]), 32'hC3);
        check("hw_wr_dout",   DataOut,       32'hDEADBEEF);
        MOV = 1'b0;
        tick();
        check("hw_wr_mfc_down", 32'(MFC), 32'd0);
        tick();

        // Byte read at 0xFF with zero wait states.
        MOV0 = 1'b1; RW = 1'b1; Size = 2'b00; Addr = 8'hFF;
        tick();
        check("b_rd_en",   32'(ram_en0),   32'd1);
        check("b_rd_addr", 32'(ram_addr0), 32'hFF);
        check("b_rd_mfc0", 32'(MFC0),      32'd0);
        tick();
        check("b_rd_mfc1", 32'(MFC0),      32'd1);
        check("b_rd_data", DataOut0,       32'h00000080);
        check("b_rd_enoff",32'(ram_en0),   32'd0);
        MOV0 = 1'b0;
        tick();
        check("b_rd_mfc_down", 32'(MFC0), 32'd0);
        tick();

        // Misaligned word and illegal size.
        MOV = 1'b1; RW = 1'b1; Size = 2'b10; Addr = 8'h02;
        tick();
        check("mis_w_en",   32'(ram_en), 32'd0);
        check("mis_w_mfc",  32'(MFC),    32'd1);
        check("mis_w_err",  32'(MemErr), 32'd1);
        check("mis_w_dout", DataOut,     32'hDEADBEEF);
        MOV = 1'b0;
        tick();
        check("mis_w_mfc_down", 32'(MFC),    32'd0);
        check("mis_w_err_down", 32'(MemErr), 32'd0);
        MOV = 1'b1; Size = 2'b11; Addr = 8'h40;
        tick();
        check("sz11_en",   32'(ram_en), 32'd0);
        check("sz11_mfc",  32'(MFC),    32'd1);
        check("sz11_err",  32'(MemErr), 32'd1);
        check("sz11_dout", DataOut,     32'hDEADBEEF);
        MOV = 1'b0;
        tick();
        MOV = 1'b1; Size = 2'b01; Addr = 8'h23;
        tick();
        check("mis_h_err", 32'(MemErr), 32'd1);
        check("mis_h_en",  32'(ram_en), 32'd0);
        MOV = 1'b0;
        tick();
        tick();

        // MOV drops after the first beat of a word read.
        MOV = 1'b1; RW = 1'b1; Size = 2'b10; Addr = 8'h30;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) MOV = 1'b0;
            check("drop_en",   32'(ram_en),   32'd1);
            check("drop_addr", 32'(ram_addr), 32'(8'h30 + 8'(i / 2)));
            check("drop_mfc",  32'(MFC),      32'd0);
            tick();
        end
        check("drop_mfc_pulse", 32'(MFC), 32'd1);
        check("drop_data",      DataOut,  32'h12345678);
        tick();
        check("drop_mfc_gone",  32'(MFC),    32'd0);
        check("drop_en_idle",   32'(ram_en), 32'd0);
        tick();
        check("drop_mfc_idle",  32'(MFC),    32'd0);

        // Reset in the middle of a word write.
        MOV = 1'b1; RW = 1'b0; Size = 2'b10; Addr = 8'h50; DataIn = 32'h11223344;
        tick(); tick(); tick();
        check("rst_mid_en_pre", 32'(ram_en), 32'd1);
        Reset = 1'b1;
        #1;
        check("rst_mid_en",  32'(ram_en), 32'd0);
        check("rst_mid_we",  32'(ram_we), 32'd0);
        check("rst_mid_mfc", 32'(MFC),    32'd0);
        wr_snap = wr_count1;
        RW = 1'b1; Size = 2'b00; Addr = 8'h10;
        tick(); tick();
        check("rst_mid_nowr",  32'(wr_count1 - wr_snap), 32'd0);
        check("rst_mid_mem52", 32'(mem1[8'h52]), 32'h00);
        check("rst_mid_mem53", 32'(mem1[8'h53]), 32'h00);
        check("rst_mid_mfc2",  32'(MFC), 32'd0);
        Reset = 1'b0;
        tick();
        check("post_rst_en",   32'(ram_en),   32'd1);
        check("post_rst_addr", 32'(ram_addr), 32'h10);
        tick(); tick();
        check("post_rst_mfc",  32'(MFC),    32'd1);
        check("post_rst_data", DataOut,     32'h000000DE);
        MOV = 1'b0;
        tick();
        check("post_rst_mfc_down", 32'(MFC), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
